// File: rtl/expand_key_reverse.sv
// AES-128 inverse key-schedule server: starting from the round-10 key, it
// regenerates round keys 10 down to 0, handing out one key per valid/ready handshake.
module expand_key_reverse #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     last_key,
  output logic [127:0]     key_out,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [IDX_W-1:0] round_idx,
  output logic             busy,
  output logic             done
);

  // Handshake: key_out/round_idx are offered while key_valid=1 and stay frozen
  // until the cycle in which key_ready=1 is seen with key_valid=1; only that
  // cycle transfers a key.
  typedef enum logic [1:0] {IDLE, PRESENT, STEP} state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_t state_q;
  state_t state_d;

  logic [7:0]   rcon;
  logic [31:0]  wa, wb, wc, wd;
  logic [31:0]  p0, p1, p2, p3, rot;
  logic [127:0] prev_key;
  logic         accept;
  logic         launch;

  always_comb begin
    rcon = 8'h00;
    case (round_idx)
      IDX_W'(1):  rcon = 8'h01;
      IDX_W'(2):  rcon = 8'h02;
      IDX_W'(3):  rcon = 8'h04;
      IDX_W'(4):  rcon = 8'h08;
      IDX_W'(5):  rcon = 8'h10;
      IDX_W'(6):  rcon = 8'h20;
      IDX_W'(7):  rcon = 8'h40;
      IDX_W'(8):  rcon = 8'h80;
      IDX_W'(9):  rcon = 8'h1b;
      IDX_W'(10): rcon = 8'h36;
      default:    rcon = 8'h00;
    endcase
  end

  // Undo one forward step: the xor chain unwinds from the last word backwards,
  // and the first word needs SubWord(RotWord()) of the recovered last word.
  assign {wa, wb, wc, wd} = key_out;
  assign p3  = wd ^ wc;
  assign p2  = wc ^ wb;
  assign p1  = wb ^ wa;
  assign rot = {p3[23:0], p3[31:24]};
  assign p0  = wa ^ {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
                  ^ {rcon, 24'h0};
  assign prev_key = {p0, p1, p2, p3};

  assign key_valid = (state_q == PRESENT);
  assign accept    = key_valid && key_ready;
  // A start coinciding with the done pulse is not taken, so done and start never act together.
  assign launch    = (state_q == IDLE) && start && !done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = PRESENT;
      PRESENT: if (accept) state_d = (round_idx == '0) ? IDLE : STEP;
      STEP:    state_d = PRESENT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      key_out   <= '0;
      round_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            key_out   <= last_key;
            round_idx <= IDX_W'(NR);
            busy      <= 1'b1;
          end
        end
        PRESENT: begin
          if (accept && round_idx == '0) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        STEP: begin
          key_out   <= prev_key;
          round_idx <= round_idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expand_key_reverse.sv
// Bench for expand_key_reverse: a forward AES-128 key expansion model predicts
// every round key; a negedge monitor pops and compares each accepted key.
module tb_expand_key_reverse;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] last_key = '0;
  logic [127:0] key_out;
  logic         key_valid;
  logic         key_ready = 1'b1;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  logic [131:0] exp_q[$];
  logic [7:0]   sbox_m [256];
  logic [127:0] rk_m [11];
  bit           ready_rand = 1'b0;

  expand_key_reverse #(.NR(10), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .last_key(last_key),
    .key_out(key_out), .key_valid(key_valid), .key_ready(key_ready),
    .round_idx(round_idx), .busy(busy), .done(done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    key_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // Plain forward key expansion w0..w43; round key r is w[4r..4r+3].
  task automatic expand_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit           acc0 = 1'b0;
  bit           stalled = 1'b0;
  logic [131:0] stall_val;

  always @(negedge clk) begin
    logic [131:0] got;
    check("done_pulse", {131'd0, done}, {131'd0, acc0});
    acc0 = 1'b0;
    got = {round_idx, key_out};
    if (stalled) begin
      check("stall_valid", {131'd0, key_valid}, 132'd1);
      check("stall_hold", got, stall_val);
    end
    stalled = 1'b0;
    if (key_valid && key_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key: got %h expected none at %0t", got, $time);
      end else begin
        logic [131:0] e;
        e = exp_q.pop_front();
        checks--;
        check("round_key", got, e);
      end
      acc0 = (round_idx == 4'd0);
    end else if (key_valid) begin
      stalled = 1'b1;
      stall_val = got;
    end
  end

  // ---------------- driver ----------------
  task automatic run_seq(input logic [127:0] key, input bit stall, input int busy_idx,
                         input int rst_idx, input bit timed);
    bit got_done = 0;
    bit pulsed = 0;
    bit did_rst = 0;
    int cycles = 0;
    expand_model(key);
    for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), rk_m[r]});
    ready_rand = stall;
    @(posedge clk); #1;
    last_key = rk_m[10];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    last_key = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) check("busy_high", {131'd0, busy}, 132'd1);
      if (done) begin
        got_done = 1;
        cycles = c;
        break;
      end
      if (busy_idx >= 0 && !pulsed && key_valid && round_idx == 4'(busy_idx)) begin
        start = 1'b1;
        last_key = {$urandom, $urandom, $urandom, $urandom};
        pulsed = 1;
      end
      if (rst_idx >= 0 && key_valid && round_idx == 4'(rst_idx)) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_key", {4'd0, key_out}, 132'd0);
        check("rst_outs", {128'd0, key_valid, round_idx == 4'd0 ? 1'b0 : 1'b1, busy, done}, 132'd0);
        check("rst_idx", {128'd0, round_idx}, 132'd0);
        exp_q.delete();
        did_rst = 1;
        break;
      end
    end
    ready_rand = 1'b0;
    if (!did_rst) begin
      checks++;
      if (!got_done) begin
        errors++;
        $display("FAIL done_timeout: got no done expected done within 2000 cycles");
      end else begin
        checks--;
        check("busy_low", {131'd0, busy}, 132'd0);
        check("queue_drained", 132'(exp_q.size()), 132'd0);
        if (timed) check("done_latency", 132'(cycles), 132'd22);
      end
    end
  endtask

  initial begin
    build_sbox();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_key", {4'd0, key_out}, 132'd0);
    check("reset_valid", {131'd0, key_valid}, 132'd0);
    check("reset_idx", {128'd0, round_idx}, 132'd0);
    check("reset_busy_done", {130'd0, busy, done}, 132'd0);

    // FIPS-197 A.1 known-answer values for the model itself
    expand_model(128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("model_rk10", {4'd0, rk_m[10]}, {4'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    check("model_rk9", {4'd0, rk_m[9]}, {4'd0, 128'hac7766f319fadc2128d12941575c006e});

    run_seq(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, -1, -1, 1);
    run_seq({$urandom, $urandom, $urandom, $urandom}, 0, 6, -1, 1);
    run_seq({$urandom, $urandom, $urandom, $urandom}, 0, -1, -1, 1);
    run_seq({$urandom, $urandom, $urandom, $urandom}, 0, -1, 4, 0);
    run_seq({$urandom, $urandom, $urandom, $urandom}, 0, -1, -1, 1);
    for (int i = 0; i < 50; i++)
      run_seq({$urandom, $urandom, $urandom, $urandom}, i[0], -1, -1, !i[0]);

    repeat (3) @(posedge clk);
    check("final_queue", 132'(exp_q.size()), 132'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
